// File: rtl/vga_pkg.sv
// ============================================================================
// vga_pkg : default 640x480@60 raster timing and shared raster constants
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_RD_LAT   = 2;

  localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int HC_W = 10;
  localparam int VC_W = 10;

  // Level driven onto hsync/vsync while inside the sync window.
  localparam logic SYNC_ACTIVE = 1'b0;

  function automatic int span_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sig_delay.sv
// ============================================================================
// sig_delay : enable-gated WIDTH x DEPTH shift register with reset value
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module sig_delay #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages[i] <= RST_VAL;
      end
    end else if (en) begin
      stages[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign q = stages[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/vga_scan.sv
// ============================================================================
// vga_scan : pixel-tick divider, raster counters, pixel request and
//            latency-aligned sync/colour output to the VGA DAC pins
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module vga_scan
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int RD_LAT   = DEF_RD_LAT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        pix_req,
  input  logic [11:0] pix_data,
  output logic        frame_start,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int H_TOT = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(H_TOT - 1);
  localparam logic [VC_W-1:0]  VC_LAST  = VC_W'(V_TOT - 1);

  // One bit wider than the counters so window ends equal to 2**W compare correctly.
  localparam logic [HC_W:0] H_VIS_END = (HC_W+1)'(H_ACTIVE);
  localparam logic [HC_W:0] HS_START  = (HC_W+1)'(H_ACTIVE + H_FP);
  localparam logic [HC_W:0] HS_END    = (HC_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VC_W:0] V_VIS_END = (VC_W+1)'(V_ACTIVE);
  localparam logic [VC_W:0] VS_START  = (VC_W+1)'(V_ACTIVE + V_FP);
  localparam logic [VC_W:0] VS_END    = (VC_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  if (CLK_DIV < 1) begin : g_chk_clk_div
    $error("vga_scan: CLK_DIV must be at least 1");
  end
  if (RD_LAT < 1) begin : g_chk_rd_lat
    $error("vga_scan: RD_LAT must be at least 1");
  end
  if (H_TOT > (1 << HC_W) || H_ACTIVE > 1024) begin : g_chk_hc_width
    $error("vga_scan: horizontal timing exceeds counter/pix_x width");
  end
  if (V_TOT > (1 << VC_W) || V_ACTIVE > 512) begin : g_chk_vc_width
    $error("vga_scan: vertical timing exceeds counter/pix_y width");
  end

  logic [DIV_W-1:0] div;
  logic             tick;
  logic [HC_W-1:0]  hc;
  logic [VC_W-1:0]  vc;
  logic             visible;
  logic             hs_n;
  logic             vs_n;
  logic [2:0]       dly;

  assign tick = (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (tick) begin
      if (hc == HC_LAST) begin
        hc <= '0;
        vc <= (vc == VC_LAST) ? '0 : vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

  always_comb begin
    visible = ({1'b0, hc} < H_VIS_END) && ({1'b0, vc} < V_VIS_END);
    hs_n    = (({1'b0, hc} >= HS_START) && ({1'b0, hc} < HS_END)) ?
              SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_n    = (({1'b0, vc} >= VS_START) && ({1'b0, vc} < VS_END)) ?
              SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_x       <= '0;
      pix_y       <= '0;
      pix_req     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && (hc == '0) && (vc == '0);
      if (tick) begin
        pix_req <= visible;
        pix_x   <= visible ? hc : '0;
        pix_y   <= visible ? vc[8:0] : '0;
      end
    end
  end

  // Blanking and syncs ride alongside the upstream read so they meet pix_data.
  sig_delay #(
    .WIDTH   (3),
    .DEPTH   (RD_LAT),
    .RST_VAL (3'b011)
  ) u_align (
    .clk (clk),
    .rst (rst),
    .en  (tick),
    .d   ({visible, hs_n, vs_n}),
    .q   (dly)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
    end else if (tick) begin
      vga_hs                <= dly[1];
      vga_vs                <= dly[0];
      {vga_b, vga_g, vga_r} <= dly[2] ? pix_data : 12'h000;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_scan.sv
// ============================================================================
// tb_vga_scan : directed checks of vga_scan on a reduced 16x10-tick raster
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_vga_scan;

  // Reduced raster: H_TOTAL=16, V_TOTAL=10, frame=160 ticks=320 clocks.
  localparam int CLK_DIV = 2;
  localparam int RD_LAT  = 2;
  localparam int HT      = 16;
  localparam int VT      = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        pix_req;
  logic [11:0] pix_data;
  logic        frame_start;
  logic        vga_hs;
  logic        vga_vs;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic [13:0] pins;

  int          checks = 0;
  int          errors = 0;
  int          t      = -1;
  int          ph     = 0;
  int          tdiv   = 0;
  logic [11:0] up_p   = 12'h000;

  always #5 clk = ~clk;

  vga_scan #(
    .CLK_DIV  (CLK_DIV),
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (3),
    .H_BP     (3),
    .V_ACTIVE (6),
    .V_FP     (1),
    .V_SYNC   (2),
    .V_BP     (1),
    .RD_LAT   (RD_LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_req     (pix_req),
    .pix_data    (pix_data),
    .frame_start (frame_start),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b)
  );

  // Upstream renderer + colour stage: one register after the address register.
  always @(posedge clk) begin
    if (rst) begin
      tdiv <= 0;
    end else if (tdiv == CLK_DIV - 1) begin
      tdiv <= 0;
      up_p <= {pix_x[3:0], pix_y[3:0], 4'hA};
    end else begin
      tdiv <= tdiv + 1;
    end
  end
  assign pix_data = up_p;
  assign pins     = {vga_hs, vga_vs, vga_b, vga_g, vga_r};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv_to(input int k);
    repeat ((k - t) * CLK_DIV - ph) @(posedge clk);
    #1;
    t  = k;
    ph = 0;
  endtask

  // Expected {hs,vs,b,g,r} after tick k: raster position of tick k-RD_LAT.
  function automatic logic [13:0] exp_pins(input int k);
    int         p;
    int         hc;
    int         vc;
    logic       vis;
    logic       hs;
    logic       vs;
    logic [3:0] hx;
    logic [3:0] vy;
    if (k < RD_LAT) return 14'h3000;
    p   = (k - RD_LAT) % (HT * VT);
    hc  = p % HT;
    vc  = p / HT;
    hx  = 4'(hc);
    vy  = 4'(vc);
    vis = (hc < 8) && (vc < 6);
    hs  = !((hc >= 10) && (hc < 13));
    vs  = !((vc >= 7) && (vc < 9));
    return {hs, vs, (vis ? {hx, vy, 4'hA} : 12'h000)};
  endfunction

  initial begin
    repeat (5) @(posedge clk);
    #1;
    chk("rst_pins", pins, 14'h3000);
    chk("rst_req", pix_req, 0);
    chk("rst_x", pix_x, 0);
    chk("rst_y", pix_y, 0);
    chk("rst_fs", frame_start, 0);
    @(negedge clk);
    rst = 1'b0;

    adv_to(0);
    chk("t0_fs", frame_start, 1);
    chk("t0_req", pix_req, 1);
    chk("t0_xy", {pix_x, pix_y}, 0);
    @(posedge clk); #1; ph++;
    chk("t0_fs_pulse", frame_start, 0);
    chk("t0_hold_req", pix_req, 1);

    adv_to(2);   chk("t2_pins", pins, 14'h300A);
    adv_to(7);   chk("t7_x", pix_x, 7); chk("t7_req", pix_req, 1);
    adv_to(8);   chk("t8_req", pix_req, 0); chk("t8_x", pix_x, 0);
    adv_to(9);   chk("t9_pins", pins, 14'h370A);
    adv_to(10);  chk("t10_pins", pins, 14'h3000);
    adv_to(11);  chk("t11_hs", vga_hs, 1);
    adv_to(12);  chk("t12_hs", vga_hs, 0);
    adv_to(14);  chk("t14_hs", vga_hs, 0);
    adv_to(15);  chk("t15_hs", vga_hs, 1);
    adv_to(80);  chk("t80_xy", {pix_x, pix_y}, {10'd0, 9'd5}); chk("t80_req", pix_req, 1);
    adv_to(87);  chk("t87_xy", {pix_x, pix_y}, {10'd7, 9'd5}); chk("t87_req", pix_req, 1);
    adv_to(89);  chk("t89_pins", pins, 14'h375A);
    adv_to(96);  chk("t96_req", pix_req, 0); chk("t96_xy", {pix_x, pix_y}, 0);
    adv_to(98);  chk("t98_pins", pins, 14'h3000);
    adv_to(113); chk("t113_vs", vga_vs, 1);
    adv_to(114); chk("t114_vs", vga_vs, 0);
    adv_to(145); chk("t145_vs", vga_vs, 0);
    adv_to(146); chk("t146_vs", vga_vs, 1);
    adv_to(159); chk("t159_fs", frame_start, 0);
    adv_to(160); chk("t160_fs", frame_start, 1); chk("t160_req", pix_req, 1);
    adv_to(162); chk("t162_pins", pins, 14'h300A);

    for (int k = 163; k <= 330; k++) begin
      adv_to(k);
      chk($sformatf("pins_t%0d", k), pins, exp_pins(k));
    end

    // Mid-frame reset at hc=5, vc=3 of the third frame.
    adv_to(373);
    chk("mid_pre_xy", {pix_x, pix_y}, {10'd5, 9'd3});
    chk("mid_pre_pins", pins, 14'h333A);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_pins", pins, 14'h3000);
    chk("mid_rst_req", pix_req, 0);
    chk("mid_rst_xy", {pix_x, pix_y}, 0);
    chk("mid_rst_fs", frame_start, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    t   = -1;
    ph  = 0;

    adv_to(0);   chk("r_t0_fs", frame_start, 1);
    adv_to(2);   chk("r_t2_pins", pins, 14'h300A);
    adv_to(12);  chk("r_t12_hs", vga_hs, 0);
    adv_to(114); chk("r_t114_vs", vga_vs, 0);
    adv_to(159); chk("r_t159_fs", frame_start, 0);
    adv_to(160); chk("r_t160_fs", frame_start, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
